vliw_stall_ctrl: RTL and testbench

Pipeline stall/flush sequencer for the two-slot VLIW core. Takes per-cycle stall requests from hazard detection, taken-branch redirects from the branch unit and a data-memory wait, and drives the PC, IF/ID and ID/EX control enables. It holds multi-cycle stalls, such as the two-bubble load-feeding-branch case, and multi-cycle branch flushes with internal counters. It also keeps saturating performance counters of lost cycles.

---
 rtl/vliw_pipe_pkg.sv | 26 ++
 rtl/vliw_stall_ctrl_if.sv | 46 ++++
 rtl/vliw_stall_ctrl_sat_counter.sv | 22 ++
 rtl/vliw_stall_ctrl.sv | 136 +++++++++++++
 tb/tb_vliw_stall_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/vliw_pipe_pkg.sv
// rtl/vliw_pipe_pkg.sv - shared types and constants for the VLIW pipeline stall/flush sequencer
package vliw_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } pipe_state_e;

    localparam logic [1:0] STALL_NONE = 2'd0;
    localparam logic [1:0] STALL_ONE  = 2'd1;
    localparam logic [1:0] STALL_TWO  = 2'd2;

    localparam int BR_PENALTY_MIN = 1;
    localparam int BR_PENALTY_MAX = 3;

    // Flush cycles beyond the one taken in RUN; out-of-range penalties are clamped.
    function automatic logic [1:0] br_extra_cycles(input int penalty);
        int p;
        p = penalty;
        if (p < BR_PENALTY_MIN) p = BR_PENALTY_MIN;
        if (p > BR_PENALTY_MAX) p = BR_PENALTY_MAX;
        return 2'(p - 1);
    endfunction

endpackage

// File: rtl/vliw_stall_ctrl_if.sv
// rtl/vliw_stall_ctrl_if.sv - hazard/branch request and pipeline enable bundle for the stall sequencer
interface vliw_stall_ctrl_if #(
    parameter int CNT_W = 16
);

    logic [1:0]       stall_req;
    logic             branch_taken;
    logic             mem_wait;
    logic             perf_clr;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             busy;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cycles;

    modport master (
        output stall_req,
        output branch_taken,
        output mem_wait,
        output perf_clr,
        input  pc_write,
        input  if_id_write,
        input  id_ex_bubble,
        input  if_id_flush,
        input  busy,
        input  stall_cycles,
        input  flush_cycles
    );

    modport slave (
        input  stall_req,
        input  branch_taken,
        input  mem_wait,
        input  perf_clr,
        output pc_write,
        output if_id_write,
        output id_ex_bubble,
        output if_id_flush,
        output busy,
        output stall_cycles,
        output flush_cycles
    );

endinterface

// File: rtl/vliw_stall_ctrl_sat_counter.sv
// rtl/vliw_stall_ctrl_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vliw_stall_ctrl.sv
// rtl/vliw_stall_ctrl.sv - stall/flush sequencer driving PC, IF/ID and ID/EX enables of the two-slot VLIW core
module vliw_stall_ctrl
    import vliw_pipe_pkg::*;
#(
    parameter int BR_PENALTY = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    vliw_stall_ctrl_if.slave  ctl
);

    localparam logic [1:0] S_RUN    = 2'(ST_RUN);
    localparam logic [1:0] S_STALL  = 2'(ST_STALL);
    localparam logic [1:0] S_FLUSH  = 2'(ST_FLUSH);
    localparam logic [1:0] BR_EXTRA = br_extra_cycles(BR_PENALTY);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       remain;
    logic [1:0]       remain_nxt;
    logic             pc_w;
    logic             if_id_w;
    logic             bubble;
    logic             flush;
    logic             stall_inc;
    logic             flush_inc;
    logic             stall_hit;
    logic             stall_two;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Reserved code 3 shares bit 1 with STALL_TWO, so it runs the two-bubble sequence.
    assign stall_hit = (ctl.stall_req != STALL_NONE);
    assign stall_two = ctl.stall_req[1];

    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        pc_w       = 1'b1;
        if_id_w    = 1'b1;
        bubble     = 1'b0;
        flush      = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        if (ctl.mem_wait) begin
            pc_w    = 1'b0;
            if_id_w = 1'b0;
        end else begin
            case (state)
                S_STALL: begin
                    pc_w      = 1'b0;
                    if_id_w   = 1'b0;
                    bubble    = 1'b1;
                    stall_inc = 1'b1;
                    remain_nxt = remain - 2'd1;
                    if (remain <= 2'd1) begin
                        state_nxt  = S_RUN;
                        remain_nxt = 2'd0;
                    end
                end
                S_FLUSH: begin
                    bubble    = 1'b1;
                    flush     = 1'b1;
                    flush_inc = 1'b1;
                    remain_nxt = remain - 2'd1;
                    if (remain <= 2'd1) begin
                        state_nxt  = S_RUN;
                        remain_nxt = 2'd0;
                    end
                end
                default: begin
                    // A hazard stall outranks a same-cycle branch; the branch is re-resolved later.
                    if (stall_hit) begin
                        pc_w      = 1'b0;
                        if_id_w   = 1'b0;
                        bubble    = 1'b1;
                        stall_inc = 1'b1;
                        if (stall_two) begin
                            state_nxt  = S_STALL;
                            remain_nxt = 2'd1;
                        end
                    end else if (ctl.branch_taken) begin
                        flush     = 1'b1;
                        flush_inc = 1'b1;
                        if (BR_EXTRA != 2'd0) begin
                            state_nxt  = S_FLUSH;
                            remain_nxt = BR_EXTRA;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_RUN;
            remain <= 2'd0;
        end else begin
            state  <= state_nxt;
            remain <= remain_nxt;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (ctl.perf_clr),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .clr   (ctl.perf_clr),
        .count (flush_cnt)
    );

    // While reset is held the front end is frozen with a bubble in ID/EX.
    assign ctl.pc_write     = rst_n & pc_w;
    assign ctl.if_id_write  = rst_n & if_id_w;
    assign ctl.id_ex_bubble = ~rst_n | bubble;
    assign ctl.if_id_flush  = rst_n & flush;
    assign ctl.busy         = rst_n & ((state == S_STALL) || (state == S_FLUSH));
    assign ctl.stall_cycles = stall_cnt;
    assign ctl.flush_cycles = flush_cnt;

endmodule

// File: tb/tb_vliw_stall_ctrl.sv
// tb/tb_vliw_stall_ctrl.sv - directed scoreboard bench for vliw_stall_ctrl with BR_PENALTY=2
module tb_vliw_stall_ctrl;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_bubble;
        logic if_id_flush;
        logic busy;
    } ctl_exp_t;

    logic     clk = 1'b0;
    logic     rst_n;
    ctl_exp_t exp_q[$];
    int       n_vec  = 0;
    int       n_miss = 0;

    always #5 clk = ~clk;

    vliw_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    vliw_stall_ctrl #(
        .BR_PENALTY (2),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic pc, input logic ifid, input logic bub,
                            input logic fl, input logic bsy);
        ctl_exp_t e;
        e.pc_write     = pc;
        e.if_id_write  = ifid;
        e.id_ex_bubble = bub;
        e.if_id_flush  = fl;
        e.busy         = bsy;
        exp_q.push_back(e);
    endtask

    task automatic compare_ctl(input string tag);
        ctl_exp_t e;
        e = exp_q.pop_front();
        chk({tag, ".pc_write"},     32'(bus.pc_write),     32'(e.pc_write));
        chk({tag, ".if_id_write"},  32'(bus.if_id_write),  32'(e.if_id_write));
        chk({tag, ".id_ex_bubble"}, 32'(bus.id_ex_bubble), 32'(e.id_ex_bubble));
        chk({tag, ".if_id_flush"},  32'(bus.if_id_flush),  32'(e.if_id_flush));
        chk({tag, ".busy"},         32'(bus.busy),         32'(e.busy));
    endtask

    // Entered and left one time unit after a rising edge; outputs sampled on the falling edge.
    task automatic step(input string tag, input logic [1:0] sr, input logic br, input logic mw,
                        input logic clr, input logic pc, input logic ifid, input logic bub,
                        input logic fl, input logic bsy);
        bus.stall_req    = sr;
        bus.branch_taken = br;
        bus.mem_wait     = mw;
        bus.perf_clr     = clr;
        push_exp(pc, ifid, bub, fl, bsy);
        @(negedge clk);
        compare_ctl(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input int exp_s, input int exp_f);
        chk({tag, ".stall_cycles"}, 32'(bus.stall_cycles), 32'(exp_s));
        chk({tag, ".flush_cycles"}, 32'(bus.flush_cycles), 32'(exp_f));
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.stall_req    = 2'd0;
        bus.branch_taken = 1'b0;
        bus.mem_wait     = 1'b0;
        bus.perf_clr     = 1'b0;
        #2;
        push_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        compare_ctl("reset");
        check_cnt("reset", 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        //    tag            sr    br mw clr  pc ifid bub fl busy
        step("idle",        2'd0, 0, 0, 0,   1, 1,   0,  0, 0);
        check_cnt("idle", 0, 0);

        step("stall1",      2'd1, 0, 0, 0,   0, 0,   1,  0, 0);
        step("stall1_done", 2'd0, 0, 0, 0,   1, 1,   0,  0, 0);
        check_cnt("stall1", 1, 0);

        step("stall2_a",    2'd2, 0, 0, 0,   0, 0,   1,  0, 0);
        step("stall2_b",    2'd0, 0, 0, 0,   0, 0,   1,  0, 1);
        step("stall2_done", 2'd0, 0, 0, 0,   1, 1,   0,  0, 0);
        check_cnt("stall2", 3, 0);

        step("wait2_a",     2'd2, 0, 0, 0,   0, 0,   1,  0, 0);
        step("wait2_frz",   2'd0, 0, 1, 0,   0, 0,   0,  0, 1);
        step("wait2_b",     2'd0, 0, 0, 0,   0, 0,   1,  0, 1);
        step("wait2_done",  2'd0, 0, 0, 0,   1, 1,   0,  0, 0);
        check_cnt("wait2", 5, 0);

        step("br_a",        2'd0, 1, 0, 0,   1, 1,   0,  1, 0);
        step("br_b",        2'd0, 0, 0, 0,   1, 1,   1,  1, 1);
        step("br_done",     2'd0, 0, 0, 0,   1, 1,   0,  0, 0);
        check_cnt("branch", 5, 2);

        step("both",        2'd1, 1, 0, 0,   0, 0,   1,  0, 0);
        step("both_done",   2'd0, 0, 0, 0,   1, 1,   0,  0, 0);
        check_cnt("both", 6, 2);

        step("stbr_a",      2'd2, 0, 0, 0,   0, 0,   1,  0, 0);
        step("stbr_b",      2'd0, 1, 0, 0,   0, 0,   1,  0, 1);
        step("stbr_done",   2'd0, 0, 0, 0,   1, 1,   0,  0, 0);
        check_cnt("stall_br", 8, 2);

        step("code3_a",     2'd3, 0, 0, 0,   0, 0,   1,  0, 0);
        step("code3_b",     2'd0, 0, 0, 0,   0, 0,   1,  0, 1);
        step("code3_done",  2'd0, 0, 0, 0,   1, 1,   0,  0, 0);
        check_cnt("code3", 10, 2);

        step("wait_run",    2'd1, 1, 1, 0,   0, 0,   0,  0, 0);
        step("wait_rel",    2'd0, 0, 0, 0,   1, 1,   0,  0, 0);
        check_cnt("wait_run", 10, 2);

        step("clr",         2'd0, 0, 0, 1,   1, 1,   0,  0, 0);
        check_cnt("clr", 0, 0);

        bus.stall_req = 2'd1;
        bus.perf_clr  = 1'b0;
        repeat (65535) @(posedge clk);
        #1;
        check_cnt("sat_fill", 65535, 0);
        step("sat_hold",    2'd1, 0, 0, 0,   0, 0,   1,  0, 0);
        check_cnt("sat_hold", 65535, 0);
        step("sat_clr",     2'd1, 0, 0, 1,   0, 0,   1,  0, 0);
        check_cnt("sat_clr", 0, 0);

        step("rbr_a",       2'd0, 1, 0, 0,   1, 1,   0,  1, 0);
        check_cnt("rbr", 0, 1);
        bus.stall_req    = 2'd0;
        bus.branch_taken = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        compare_ctl("mid_flush_rst");
        check_cnt("mid_flush_rst", 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst",    2'd0, 0, 0, 0,   1, 1,   0,  0, 0);
        check_cnt("post_rst", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
